bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
// - Central arbiter for the shared serial system bus.
//   - Receives breq from up to NUM_MASTERS master ports.
//   - Drives one-hot bgrant back to them and a grant_id select to the bus mux.
// - Supports one outstanding split transaction:
//   - On slave split, the owning master is parked and the bus is freed for others.
//   - The parked master is re-granted with top priority once the slave signals resume.
// PARAMETERS
// - NUM_MASTERS  2  number of requesting master ports (2..8)
// - IDW          $clog2(NUM_MASTERS)  width of grant_id (derived, not overridden)
// PORTS
// - clk       in   1    system clock; all logic on rising edge
// - rstn      in   1    asynchronous active-low reset
// - breq      in   N    bus request per master; held high for whole ownership
// - bgrant    out  N    one-hot grant per master (all-zero when bus idle)
// - grant_id  out  IDW  index of granted master; valid while bus_busy=1
// - bus_busy  out  1    high while any bgrant bit is set
// - s_split   in   1    1-cycle pulse from addressed slave: split current transaction
// - s_resume  in   1    1-cycle pulse from split slave: data ready, re-grant owner
// - m_split   out  N    per-master split flag; high while that master is parked
// - split_err out  1    sticky: s_split seen while a split was already pending
// BEHAVIOUR
// - Reset:
//   - bgrant=0, grant_id=0, bus_busy=0, m_split=0, split_err=0.
//   - State IDLE; no split pending; resume-priority flag clear.
// - FSM arb_state_t: IDLE, BUSY. All outputs registered.
// - Eligible set elig = breq & ~m_split.
// - IDLE:
//   - If elig!=0 at edge n: enter BUSY.
//   - bgrant/grant_id for the winner are valid from cycle n+1 (1-cycle grant latency).
//   - Winner: parked-resumed master if resume flag set and it requests; else lowest index in elig.
//   - Resume flag clears when that master is granted.
// - BUSY:
//   - Grant held while breq[grant_id]=1. Other requests have no effect (no pre-emption).
//   - breq[grant_id]=0 sampled at edge m: bgrant=0 from m+1, state IDLE.
//   - Earliest next grant is m+2, giving one mandatory dead/turnaround cycle.
// - Split:
//   - s_split in BUSY with no split pending, at edge n:
//     - bgrant=0 from n+1; m_split[grant_id]=1 from n+1; record split owner; state IDLE.
//   - s_split in IDLE is ignored.
//   - s_split while a split is pending: split_err=1 (sticky); request ignored; grant unchanged.
// - Resume:
//   - s_resume at edge r with split pending: m_split[owner]=0 from r+1; set resume flag.
//   - Owner wins next IDLE arbitration if it requests. If it does not request, the flag
//     persists and others may still be granted.
//   - s_resume with no split pending is ignored.
// - Simultaneous s_split and s_resume (split pending): resume is processed first.
//   - The new split is then accepted (no split_err).
//   - New owner = current grant_id.
// - Owner drops breq while parked: m_split stays set until s_resume (slave still owes data).
// - Async reset mid-grant: all outputs drop immediately.
//   - Pending split and resume flag are lost. Masters must restart.
// - Widths: grant_id is zero-extended index. bgrant is one-hot or zero, never multi-hot.
// STRUCTURE
// - bus_pkg:
//   - arb_state_t enum {IDLE, BUSY}.
//   - localparam NUM_MASTERS default.
//   - Function onehot(idx) shared with the bus mux.
// - Sub-module prio_enc: parameterised lowest-index-first priority encoder.
//   - Input: N-bit request. Outputs: valid, index.
//   - Instantiated once on elig.
// - Top keeps the FSM, split-owner register, resume flag and output registers.
// TESTING
// - Single request: breq=2'b10 at edge 3
//   -> bgrant=2'b10, grant_id=1, bus_busy=1 from cycle 4; hold 10 cycles, then breq=0
//   -> bgrant=0 next cycle.
// - Contention: breq=2'b11 from idle -> master0 granted.
//   - master0 drops breq at edge m -> bgrant=0 at m+1, bgrant=2'b10 at m+2.
// - Split/resume: master0 BUSY, s_split pulse -> next cycle bgrant=0, m_split=2'b01;
//   master1 requesting -> granted one cycle later.
//   - s_resume pulse -> m_split=0.
//   - master1 releases -> master0 granted ahead of any new master1 request.
// - Double split: split pending, s_split again (no resume) -> split_err=1 and stays 1;
//   bgrant unchanged.
// - Simultaneous s_split+s_resume: owner0 pending, master1 BUSY
//   -> m_split=2'b10 next cycle, split_err=0.
// - Reset mid-grant: rstn=0 asynchronously while bgrant=2'b01 and m_split=2'b10
//   -> all outputs 0 before next clk edge.
//   - After rstn=1, a fresh request is granted with 1-cycle latency.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the system bus arbiter and the bus mux.
package bus_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam int NUM_MASTERS = 2;
   localparam int MAX_MASTERS = 8;

   // One-hot decode of a master index, sized for the largest supported bus.
   function automatic logic [MAX_MASTERS-1:0] onehot(input logic [2:0] idx);
      logic [MAX_MASTERS-1:0] vec;
      vec      = '0;
      vec[idx] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/bus_arbiter_prio_enc.sv
// Lowest-index-first priority encoder over an N-bit request vector.
module prio_enc #(
   parameter  int N = 2,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   output logic         valid,
   output logic [W-1:0] idx
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      valid = |req;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) idx = W'(i);
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Central bus arbiter: one-hot grant, no pre-emption, one outstanding split
// transaction with top-priority re-grant of the parked master on resume.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter  int NUM_MASTERS = bus_pkg::NUM_MASTERS,
   localparam int IDW         = $clog2(NUM_MASTERS)
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [NUM_MASTERS-1:0] breq,
   output logic [NUM_MASTERS-1:0] bgrant,
   output logic [IDW-1:0]         grant_id,
   output logic                   bus_busy,
   input  logic                   s_split,
   input  logic                   s_resume,
   output logic [NUM_MASTERS-1:0] m_split,
   output logic                   split_err
);

   arb_state_t             state, state_nxt;
   logic [NUM_MASTERS-1:0] bgrant_nxt, m_split_nxt, elig;
   logic [IDW-1:0]         grant_id_nxt, split_owner, split_owner_nxt;
   logic [IDW-1:0]         resume_id, resume_id_nxt, win_id, enc_idx;
   logic                   bus_busy_nxt, split_err_nxt, resume_flag, resume_flag_nxt;
   logic                   enc_valid, win, split_pending, resume_now;

   assign elig          = breq & ~m_split;
   assign split_pending = |m_split;
   assign resume_now    = s_resume && split_pending;

   prio_enc #(.N(NUM_MASTERS)) u_prio_enc (
      .req   (elig),
      .valid (enc_valid),
      .idx   (enc_idx)
   );

   // Resume is applied after arbitration so a resume arriving on the same
   // edge that grants a previously resumed master still leaves its flag set.
   always_comb begin
      state_nxt       = state;
      bgrant_nxt      = bgrant;
      grant_id_nxt    = grant_id;
      m_split_nxt     = m_split;
      split_owner_nxt = split_owner;
      resume_flag_nxt = resume_flag;
      resume_id_nxt   = resume_id;
      split_err_nxt   = split_err;
      win             = 1'b0;
      win_id          = enc_idx;

      case (state)
         IDLE: begin
            if (resume_flag && breq[resume_id]) begin
               win    = 1'b1;
               win_id = resume_id;
            end else if (enc_valid) begin
               win    = 1'b1;
               win_id = enc_idx;
            end
            if (win) begin
               state_nxt    = BUSY;
               bgrant_nxt   = NUM_MASTERS'(onehot(3'(win_id)));
               grant_id_nxt = win_id;
               if (win_id == resume_id) resume_flag_nxt = 1'b0;
            end
         end
         BUSY: begin
            if (s_split && (!split_pending || resume_now)) begin
               m_split_nxt[grant_id] = 1'b1;
               split_owner_nxt       = grant_id;
               bgrant_nxt            = '0;
               state_nxt             = IDLE;
            end else begin
               if (s_split) split_err_nxt = 1'b1;
               if (!breq[grant_id]) begin
                  bgrant_nxt = '0;
                  state_nxt  = IDLE;
               end
            end
         end
         default: begin
            bgrant_nxt = '0;
            state_nxt  = IDLE;
         end
      endcase

      if (resume_now) begin
         m_split_nxt[split_owner] = 1'b0;
         resume_flag_nxt          = 1'b1;
         resume_id_nxt            = split_owner;
      end

      bus_busy_nxt = (state_nxt == BUSY);
   end

   // All outputs are registered; reset drops them without waiting for a clock.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         bgrant      <= '0;
         grant_id    <= '0;
         bus_busy    <= 1'b0;
         m_split     <= '0;
         split_err   <= 1'b0;
         split_owner <= '0;
         resume_flag <= 1'b0;
         resume_id   <= '0;
      end else begin
         state       <= state_nxt;
         bgrant      <= bgrant_nxt;
         grant_id    <= grant_id_nxt;
         bus_busy    <= bus_busy_nxt;
         m_split     <= m_split_nxt;
         split_err   <= split_err_nxt;
         split_owner <= split_owner_nxt;
         resume_flag <= resume_flag_nxt;
         resume_id   <= resume_id_nxt;
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed scenarios plus random traffic
// checked against an ownership-level reference model.
module tb_bus_arbiter;

   localparam int N   = 4;
   localparam int IDW = $clog2(N);

   logic           clk = 1'b0;
   logic           rstn = 1'b0;
   logic [N-1:0]   breq = '0;
   logic           s_split = 1'b0;
   logic           s_resume = 1'b0;
   logic [N-1:0]   bgrant, m_split;
   logic [IDW-1:0] grant_id;
   logic           bus_busy, split_err;

   typedef struct {
      logic [N-1:0]   bgrant;
      logic [IDW-1:0] gid;
      logic           busy;
      logic [N-1:0]   msplit;
      logic           err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: who owns the bus, who is parked, who is owed priority.
   int owner      = -1;
   int parked     = -1;
   int resume_who = -1;
   bit err_m      = 1'b0;

   bus_arbiter #(.NUM_MASTERS(N)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .breq      (breq),
      .bgrant    (bgrant),
      .grant_id  (grant_id),
      .bus_busy  (bus_busy),
      .s_split   (s_split),
      .s_resume  (s_resume),
      .m_split   (m_split),
      .split_err (split_err)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      owner      = -1;
      parked     = -1;
      resume_who = -1;
      err_m      = 1'b0;
   endfunction

   // Advance the model by one rising edge using the inputs currently driven.
   function automatic void model_step();
      int  p_old   = parked;
      int  r_old   = resume_who;
      bit  resumed = s_resume && (p_old >= 0);
      int  new_parked = resumed ? -1 : p_old;
      int  new_resume = r_old;
      if (owner < 0) begin
         if (r_old >= 0 && breq[r_old]) begin
            owner = r_old;
         end else begin
            for (int i = 0; i < N; i++) begin
               if (breq[i] && i != p_old) begin
                  owner = i;
                  break;
               end
            end
         end
         if (owner >= 0 && owner == r_old) new_resume = -1;
      end else begin
         if (s_split && (p_old < 0 || s_resume)) begin
            new_parked = owner;
            owner      = -1;
         end else begin
            if (s_split) err_m = 1'b1;
            if (!breq[owner]) owner = -1;
         end
      end
      if (resumed) new_resume = p_old;
      parked     = new_parked;
      resume_who = new_resume;
   endfunction

   task automatic push_expect();
      exp_t e;
      e.busy   = (owner >= 0);
      e.bgrant = e.busy ? (N'(1) << owner) : '0;
      e.gid    = e.busy ? IDW'(owner) : '0;
      e.msplit = (parked >= 0) ? (N'(1) << parked) : '0;
      e.err    = err_m;
      exp_q.push_back(e);
   endtask

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      checkValue("bgrant", 32'(bgrant), 32'(e.bgrant));
      checkValue("bus_busy", 32'(bus_busy), 32'(e.busy));
      checkValue("m_split", 32'(m_split), 32'(e.msplit));
      checkValue("split_err", 32'(split_err), 32'(e.err));
      if (e.busy) checkValue("grant_id", 32'(grant_id), 32'(e.gid));
   endtask

   // Monitor: pops one expectation per rising edge, sampled just after it.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput(e);
         end
      end
   end

   task automatic applyStimulus(input logic [N-1:0] req, input logic sp, input logic rs);
      @(negedge clk);
      breq     = req;
      s_split  = sp;
      s_resume = rs;
      if (rstn) model_step();
      else model_reset();
      push_expect();
   endtask

   task automatic applyHold(input logic [N-1:0] req, input int cycles);
      for (int i = 0; i < cycles; i++) applyStimulus(req, 1'b0, 1'b0);
   endtask

   task automatic applyReset(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         rstn     = 1'b0;
         breq     = '0;
         s_split  = 1'b0;
         s_resume = 1'b0;
         model_reset();
         push_expect();
      end
   endtask

   task automatic releaseReset();
      @(negedge clk);
      rstn = 1'b1;
      model_reset();
      push_expect();
   endtask

   // Drop reset between clock edges and look at the outputs before the next edge.
   task automatic applyAsyncReset();
      @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      checkValue("async_reset_bgrant", 32'(bgrant), 32'd0);
      checkValue("async_reset_busy", 32'(bus_busy), 32'd0);
      checkValue("async_reset_m_split", 32'(m_split), 32'd0);
      checkValue("async_reset_split_err", 32'(split_err), 32'd0);
      checkValue("async_reset_grant_id", 32'(grant_id), 32'd0);
   endtask

   initial begin
      logic [N-1:0] r;
      applyReset(2);
      releaseReset();

      // Single request, held then released.
      applyHold(4'b0010, 11);
      applyHold(4'b0000, 2);

      // Contention from idle, then master0 releases.
      applyHold(4'b0011, 5);
      applyHold(4'b0010, 4);
      applyHold(4'b0000, 2);

      // Split master2, master1 takes over, resume, master2 wins ahead of master1.
      applyHold(4'b0100, 2);
      applyStimulus(4'b0110, 1'b1, 1'b0);
      applyHold(4'b0110, 3);
      applyStimulus(4'b0110, 1'b0, 1'b1);
      applyHold(4'b0100, 1);
      applyHold(4'b0110, 4);
      applyHold(4'b0000, 2);

      // Reset while master0 owns the bus and master1 is parked.
      applyHold(4'b0010, 2);
      applyStimulus(4'b0011, 1'b1, 1'b0);
      applyHold(4'b0001, 3);
      applyAsyncReset();
      applyReset(1);
      releaseReset();
      applyHold(4'b0100, 3);
      applyHold(4'b0000, 2);

      // Simultaneous split and resume: owner0 pending, master1 busy.
      applyHold(4'b0001, 2);
      applyStimulus(4'b0011, 1'b1, 1'b0);
      applyHold(4'b0010, 2);
      applyStimulus(4'b0010, 1'b1, 1'b1);
      applyHold(4'b0000, 3);
      applyStimulus(4'b0000, 1'b0, 1'b1);
      applyHold(4'b0000, 2);

      // Double split: second split while one is pending sets the sticky error.
      applyHold(4'b0100, 2);
      applyStimulus(4'b0100, 1'b1, 1'b0);
      applyHold(4'b0010, 2);
      applyStimulus(4'b0010, 1'b1, 1'b0);
      applyHold(4'b0010, 3);
      applyHold(4'b0000, 2);

      // Random traffic from a clean reset.
      applyReset(1);
      releaseReset();
      r = '0;
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
         end
         applyStimulus(r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      end
      applyHold(4'b0000, 2);

      @(posedge clk);
      @(posedge clk);
      #2;
      checkValue("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
